uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller between `uart_rx` and the Wishbone register file.
- Captures each `o_data_ready_w` pulse and the byte from `uart_rx` into an internal FIFO.
- Serves bus-side pop requests.
- Tracks level, overrun and a character-gap timeout.
- Produces one registered interrupt line for the bus interface.

## Interface
- `DATA_BITS`, 8, width of a received character (matches `uart_rx`)
- `FIFO_DEPTH`, 16, FIFO entries; power of two, 2..256
- `CYCLES_PER_BIT`, 108, clocks per bit; used for the timeout period
- `TIMEOUT_CHARS`, 4, idle character times before the timeout fires

Ports:
- `i_clk` in 1 system clock
- `i_rst` in 1 reset; one clock; reset is asynchronous and active-high
- `i_rx_data_ready` in 1 one-cycle pulse from `uart_rx` `o_data_ready_w`
- `i_rx_data` in DATA_BITS byte from `uart_rx` `o_data_w`
- `i_rx_busy` in 1 `uart_rx` `o_busy`
- `i_rd_en` in 1 pop request from the bus side
- `o_rd_data` out DATA_BITS popped byte
- `o_rd_valid` out 1 one-cycle pulse; `o_rd_data` is valid
- `o_empty` out 1 FIFO empty
- `o_full` out 1 FIFO full
- `o_level` out $clog2(FIFO_DEPTH)+1 entries held
- `i_irq_threshold` in $clog2(FIFO_DEPTH)+1 level interrupt threshold; 0 disables the level source
- `i_overrun_clr` in 1 clears the sticky overrun flag
- `o_overrun` out 1 sticky overrun flag
- `o_timeout` out 1 timeout flag
- `o_irq` out 1 interrupt

## Operation
- **Push:** on `i_rx_data_ready`, `i_rx_data` is written at the write pointer.
  - If the FIFO is full and there is no pop in the same cycle, the byte is dropped and `o_overrun` is set.
- **Pop:** on `i_rd_en` with `!o_empty`, the head is read.
  - `o_rd_data` updates and `o_rd_valid` pulses on the next edge.
  - `i_rd_en` while empty is ignored: no pulse, `o_rd_data` holds its value.
- **Pointers:** $clog2(FIFO_DEPTH)+1 bits, with an extra wrap bit.
  - full = addresses equal and wrap bits differ.
  - empty = pointers equal.
  - `o_level` = wr − rd, modulo 2^(width).
- **Simultaneous push+pop:**
  - When full, both succeed and there is no overrun.
  - When empty, only the push succeeds.
  - Level is unchanged whenever both succeed.
- **Overrun flag:** sticky. `i_overrun_clr` clears it. Set wins over clear in the same cycle.
- **Timeout FSM** (`TO_IDLE`, `TO_COUNT`, `TO_FIRED`):
  - `TO_IDLE` → `TO_COUNT` when the FIFO is non-empty and `i_rx_busy` = 0. The counter loads `TIMEOUT_CHARS*10*CYCLES_PER_BIT-1`.
  - `TO_COUNT`: decrement each cycle. Reload on a push, a pop, or `i_rx_busy`=1. Go to `TO_IDLE` if the FIFO becomes empty. At 0, go to `TO_FIRED`.
  - `TO_FIRED`: `o_timeout`=1. Any pop, or the FIFO becoming empty, returns to `TO_IDLE`. A push returns to `TO_COUNT` with a reload.
  - Counter width: $clog2(TIMEOUT_CHARS*10*CYCLES_PER_BIT).
- **Interrupt:** `o_irq` is registered and equals OR of:
  - (`i_irq_threshold`≠0 && `o_level` ≥ `i_irq_threshold`)
  - `o_timeout`
  - `o_overrun`

## Timing
- **Reset values:**
  - `o_empty`=1
  - `o_rd_data`=0
  - `o_rd_valid`, `o_full`, `o_level`, `o_overrun`, `o_timeout`, `o_irq` = 0
  - FSM in `TO_IDLE`, pointers 0
- Reset mid-operation discards FIFO contents and flags immediately (asynchronous).
- Push to visibility: `o_level`/`o_empty`/`o_full` update on the edge sampling `i_rx_data_ready`, i.e. 1 cycle.
- Pop latency: 1 cycle from `i_rd_en` to `o_rd_valid`. Back-to-back pops every cycle are supported.
- `o_irq` lags its sources by 1 cycle.
- Timeout fires exactly `TIMEOUT_CHARS*10*CYCLES_PER_BIT` cycles after the last qualifying event, plus 1 cycle from the `TO_IDLE`→`TO_COUNT` transition.

## Configuration
- `UART_RX_TIMEOUT_EN` defined:
  - Timeout FSM and counter are built.
  - `o_timeout` behaves as above.
- Not defined:
  - FSM and counter are removed.
  - `o_timeout` is tied to 0.
  - `o_irq` has only the level and overrun sources.
  - `TIMEOUT_CHARS` is ignored.

## Structure
- **Shared package `uart_pkg`:**
  - timeout state encoding `TO_IDLE`/`TO_COUNT`/`TO_FIRED`
  - `UART_FRAME_BITS` = 10 (start + 8 data + stop)
  - pointer/level width helper constant
- **One sub-module `uart_sync_fifo`:**
  - Parameters: `DATA_BITS`, `FIFO_DEPTH`.
  - Ports: push, pop, data in/out, full, empty, level.
  - `uart_rx_ctrl` owns the overrun, timeout and irq logic around it.

## Test plan
- Push 0xA5, 0x3C; pop twice → `o_rd_data` 0xA5 then 0x3C, each with an `o_rd_valid` pulse. `o_level` goes 2→1→0, `o_empty`=1.
- Push 17 bytes with FIFO_DEPTH=16 and no pop → `o_full`=1, 17th byte dropped, `o_overrun`=1, `o_irq`=1. `i_overrun_clr` drops `o_overrun`. First pop returns byte 1.
- With the FIFO full, assert push and pop in the same cycle → no overrun, `o_level` stays 16, the new byte is read last.
- `i_irq_threshold`=4, push 3 bytes → `o_irq`=0. Push a 4th → `o_irq`=1 one cycle later. Pop one → `o_irq`=0.
- `UART_RX_TIMEOUT_EN`, TIMEOUT_CHARS=1, CYCLES_PER_BIT=4: push 1 byte, then idle → `o_timeout`=1 after 41 cycles. A pop clears it. `i_rx_busy`=1 during the wait restarts the count.
- Assert `i_rst` mid-burst with 5 bytes held → all outputs return to reset values asynchronously. After release, the first push and pop returns the new byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: timeout FSM states,
// frame length and the FIFO pointer/level width helper.
package uart_pkg;

  // Character-gap timeout states.
  typedef enum logic [1:0] {
    TO_IDLE  = 2'd0,
    TO_COUNT = 2'd1,
    TO_FIRED = 2'd2
  } to_state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned UART_FRAME_BITS = 10;

  // Pointer/level width: address bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Bus-side and uart_rx-side signals of uart_rx_ctrl.
// master: drives the i_* signals; slave: the controller itself.
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned LW = ptr_width(FIFO_DEPTH);

  logic                 i_rx_data_ready;
  logic [DATA_BITS-1:0] i_rx_data;
  logic                 i_rx_busy;
  logic                 i_rd_en;
  logic [DATA_BITS-1:0] o_rd_data;
  logic                 o_rd_valid;
  logic                 o_empty;
  logic                 o_full;
  logic [LW-1:0]        o_level;
  logic [LW-1:0]        i_irq_threshold;
  logic                 i_overrun_clr;
  logic                 o_overrun;
  logic                 o_timeout;
  logic                 o_irq;

  modport master (
    output i_rx_data_ready, i_rx_data, i_rx_busy, i_rd_en,
           i_irq_threshold, i_overrun_clr,
    input  o_rd_data, o_rd_valid, o_empty, o_full, o_level,
           o_overrun, o_timeout, o_irq
  );

  modport slave (
    input  i_rx_data_ready, i_rx_data, i_rx_busy, i_rd_en,
           i_irq_threshold, i_overrun_clr,
    output o_rd_data, o_rd_valid, o_empty, o_full, o_level,
           o_overrun, o_timeout, o_irq
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for received characters. Pointers carry an extra wrap
// bit so full and empty are distinguishable; a push into a full FIFO is
// only accepted when a pop frees the head slot in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_BITS  = 8,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned LW         = ptr_width(FIFO_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic [LW-1:0]        level
);
  localparam int unsigned    AW      = LW - 1;
  localparam logic [LW-1:0]  PTR_ONE = LW'(1);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [LW-1:0]        wr_ptr;
  logic [LW-1:0]        rd_ptr;
  logic                 pop_ok;
  logic                 push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Registered read port: head byte plus one-cycle valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: buffers bytes from uart_rx in a FIFO, serves
// bus pops, keeps a sticky overrun flag, a character-gap timeout and a
// registered interrupt. Define UART_RX_TIMEOUT_EN to build the timeout
// FSM; otherwise o_timeout is tied low.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned CYCLES_PER_BIT = 108,
  parameter int unsigned TIMEOUT_CHARS  = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  uart_rx_ctrl_if.slave bus
);
  localparam int unsigned LW = ptr_width(FIFO_DEPTH);

  logic          push;
  logic          pop_ok;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          overrun;
  logic          timeout;
  logic          level_hit;
  logic          irq;

  assign push   = bus.i_rx_data_ready;
  assign pop_ok = bus.i_rd_en && !empty;

  uart_sync_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (push),
    .pop      (bus.i_rd_en),
    .wr_data  (bus.i_rx_data),
    .rd_data  (bus.o_rd_data),
    .rd_valid (bus.o_rd_valid),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // Sticky overrun: a dropped byte sets it, set beats a same-cycle clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overrun <= 1'b0;
    end else if (push && full && !pop_ok) begin
      overrun <= 1'b1;
    end else if (bus.i_overrun_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned    TO_CYCLES = TIMEOUT_CHARS * UART_FRAME_BITS * CYCLES_PER_BIT;
  localparam int unsigned    CW        = $clog2(TO_CYCLES);
  localparam logic [CW-1:0]  TO_LOAD   = CW'(TO_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  to_state_t     state;
  to_state_t     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  // Timeout state and down-counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= TO_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: any FIFO or receiver activity restarts the gap count.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      TO_IDLE: begin
        if (!empty && !bus.i_rx_busy) begin
          state_nx = TO_COUNT;
          cnt_nx   = TO_LOAD;
        end
      end
      TO_COUNT: begin
        if (empty) begin
          state_nx = TO_IDLE;
        end else if (push || pop_ok || bus.i_rx_busy) begin
          cnt_nx = TO_LOAD;
        end else if (cnt == '0) begin
          state_nx = TO_FIRED;
        end else begin
          cnt_nx = cnt - CNT_ONE;
        end
      end
      TO_FIRED: begin
        if (pop_ok || empty) begin
          state_nx = TO_IDLE;
        end else if (push) begin
          state_nx = TO_COUNT;
          cnt_nx   = TO_LOAD;
        end
      end
      default: state_nx = TO_IDLE;
    endcase
  end

  assign timeout = (state == TO_FIRED);
`else
  assign timeout = 1'b0;
`endif

  assign level_hit = (bus.i_irq_threshold != '0) && (level >= bus.i_irq_threshold);

  // Interrupt is registered, so it trails its sources by one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq <= 1'b0;
    end else begin
      irq <= level_hit || timeout || overrun;
    end
  end

  assign bus.o_empty   = empty;
  assign bus.o_full    = full;
  assign bus.o_level   = level;
  assign bus.o_overrun = overrun;
  assign bus.o_timeout = timeout;
  assign bus.o_irq     = irq;

endmodule
